gmii_rx_framer: RTL and testbench

Consumes the GMII receive stream produced by the SGMII RX buffer, on the same 125 MHz domain. Strips the preamble and SFD, checks the frame length, and checks the Ethernet CRC-32 FCS. Emits payload bytes (DA through end of data, FCS removed) with sop/eop framing and a per-frame error flag on eop. Pulses per-frame status strobes for the MAC statistics counters.

---
 rtl/gmii_rx_framer.sv | 166 ++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks length and CRC-32, and emits payload with sop/eop/err plus stat pulses.
// Latency: payload byte k is registered on the edge that samples byte k+5; eop and stat pulses are registered on the first dv-low edge.
// Backpressure: none; the GMII stream cannot be stalled, so the output must always be accepted.
module gmii_rx_framer #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522
) (
  input  logic       clk_125mhz,
  input  logic       rst_n,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_err,
  output logic       stat_good,
  output logic       stat_crc_err,
  output logic       stat_len_err,
  output logic       stat_phy_err,
  output logic       stat_pre_err
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [13:0] MIN_LEN     = 14'(MIN_FRAME);
  localparam logic [13:0] MAX_LEN     = 14'(MAX_FRAME);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t      state, state_nxt;
  logic        pre_err_nxt;
  logic [31:0] crc;
  logic [13:0] len;
  logic        phy;
  logic [31:0] fcs_sr;
  logic [2:0]  sr_cnt;
  logic [7:0]  p_dat;
  logic        p_vld;
  logic        first;
  logic        sfd, frame_end, len_bad, crc_bad;

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pre_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) begin
          if (!gmii_rx_err && gmii_rxd == 8'h55)      state_nxt = PREAMBLE;
          else if (!gmii_rx_err && gmii_rxd == 8'hD5) state_nxt = DATA;
          else begin
            state_nxt   = DROP;
            pre_err_nxt = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv)                            state_nxt = IDLE;
        else if (!gmii_rx_err && gmii_rxd == 8'h55) state_nxt = PREAMBLE;
        else if (!gmii_rx_err && gmii_rxd == 8'hD5) state_nxt = DATA;
        else begin
          state_nxt   = DROP;
          pre_err_nxt = 1'b1;
        end
      end
      DATA:    if (!gmii_rx_dv) state_nxt = IDLE;
      DROP:    if (!gmii_rx_dv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sfd       = (state != DATA) && (state_nxt == DATA);
    frame_end = (state == DATA) && !gmii_rx_dv;
    len_bad   = (len < MIN_LEN) || (len > MAX_LEN);
    crc_bad   = (crc != CRC_RESIDUE);
  end

  // Four-byte holding register keeps the FCS out of the payload; P is the next byte to emit.
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      crc          <= 32'hFFFFFFFF;
      len          <= '0;
      phy          <= 1'b0;
      fcs_sr       <= '0;
      sr_cnt       <= '0;
      p_dat        <= '0;
      p_vld        <= 1'b0;
      first        <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_err      <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_phy_err <= 1'b0;
      stat_pre_err <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_err      <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_phy_err <= 1'b0;
      stat_pre_err <= pre_err_nxt;
      if (sfd) begin
        crc    <= 32'hFFFFFFFF;
        len    <= '0;
        phy    <= 1'b0;
        sr_cnt <= '0;
        p_vld  <= 1'b0;
        first  <= 1'b1;
      end else if (state == DATA && gmii_rx_dv) begin
        crc    <= crc_byte(crc, gmii_rxd);
        if (len != 14'h3FFF) len <= len + 14'd1;
        if (gmii_rx_err) phy <= 1'b1;
        fcs_sr <= {fcs_sr[23:0], gmii_rxd};
        if (sr_cnt == 3'd4) begin
          p_dat <= fcs_sr[31:24];
          p_vld <= 1'b1;
        end else begin
          sr_cnt <= sr_cnt + 3'd1;
        end
        if (p_vld) begin
          out_data  <= p_dat;
          out_valid <= 1'b1;
          out_sop   <= first;
          first     <= 1'b0;
        end
      end else if (frame_end) begin
        if (p_vld) begin
          out_data  <= p_dat;
          out_valid <= 1'b1;
          out_sop   <= first;
          out_eop   <= 1'b1;
          out_err   <= phy | len_bad | crc_bad;
        end
        // Exactly one status pulse per frame, phy > len > crc > good.
        stat_phy_err <= phy;
        stat_len_err <= !phy && len_bad;
        stat_crc_err <= !phy && !len_bad && crc_bad;
        stat_good    <= !phy && !len_bad && !crc_bad;
        p_vld        <= 1'b0;
        first        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: table of frame scenarios plus a mid-frame reset sequence, checked through cycle-stamped scoreboards.
module tb_gmii_rx_framer;

  logic       clk_125mhz = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] gmii_rxd = 8'h00;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_err = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop, out_err;
  logic       stat_good, stat_crc_err, stat_len_err, stat_phy_err, stat_pre_err;

  always #4 clk_125mhz = ~clk_125mhz;

  gmii_rx_framer dut (
    .clk_125mhz  (clk_125mhz),
    .rst_n       (rst_n),
    .gmii_rxd    (gmii_rxd),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rx_err (gmii_rx_err),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_err     (out_err),
    .stat_good   (stat_good),
    .stat_crc_err(stat_crc_err),
    .stat_len_err(stat_len_err),
    .stat_phy_err(stat_phy_err),
    .stat_pre_err(stat_pre_err)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic        err;
    logic [31:0] cyc;
  } obs_t;

  typedef struct packed {
    logic [4:0]  st;
    logic [31:0] cyc;
  } sobs_t;

  typedef struct {
    int         pre_n;
    bit         pre_bad;
    int         nbytes;
    bit         corrupt;
    int         err_at;
    logic [4:0] exp;
  } vec_t;

  // stat vector order: {good, crc, len, phy, pre}
  localparam logic [4:0] S_GOOD = 5'b10000;
  localparam logic [4:0] S_CRC  = 5'b01000;
  localparam logic [4:0] S_LEN  = 5'b00100;
  localparam logic [4:0] S_PHY  = 5'b00010;
  localparam logic [4:0] S_PRE  = 5'b00001;

  obs_t       oq[$];
  sobs_t      sq[$];
  logic [7:0] fr[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  always @(posedge clk_125mhz) begin
    obs_t  a, x;
    sobs_t sa, sx;
    cyc = cyc + 1;
    #1;
    if (out_valid === 1'b1) begin
      a.d   = out_data;
      a.sop = out_sop;
      a.eop = out_eop;
      a.err = out_eop ? out_err : 1'b0;
      a.cyc = 32'(cyc);
      n_vec++;
      if (oq.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got d=%h sop=%b eop=%b err=%b cyc=%0d, want no output", a.d, a.sop, a.eop, a.err, a.cyc);
      end else begin
        x = oq.pop_front();
        if (a !== x) begin
          n_bad++;
          $display("FAIL out_byte: got d=%h sop=%b eop=%b err=%b cyc=%0d, want d=%h sop=%b eop=%b err=%b cyc=%0d",
                   a.d, a.sop, a.eop, a.err, a.cyc, x.d, x.sop, x.eop, x.err, x.cyc);
        end
      end
    end
    while (oq.size() > 0 && oq[0].cyc < 32'(cyc)) begin
      x = oq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL out_missing: got nothing at cyc=%0d, want d=%h sop=%b eop=%b", x.cyc, x.d, x.sop, x.eop);
    end
    sa.st  = {stat_good, stat_crc_err, stat_len_err, stat_phy_err, stat_pre_err};
    sa.cyc = 32'(cyc);
    if (sa.st !== 5'b00000) begin
      n_vec++;
      if (sq.size() == 0) begin
        n_bad++;
        $display("FAIL stat_unexpected: got %b cyc=%0d, want none", sa.st, sa.cyc);
      end else begin
        sx = sq.pop_front();
        if (sa !== sx) begin
          n_bad++;
          $display("FAIL stat_pulse: got %b cyc=%0d, want %b cyc=%0d", sa.st, sa.cyc, sx.st, sx.cyc);
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc < 32'(cyc)) begin
      sx = sq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL stat_missing: got nothing at cyc=%0d, want %b", sx.cyc, sx.st);
    end
  end

  task automatic drv(input logic dv, input logic [7:0] d, input logic er, output int e);
    @(negedge clk_125mhz);
    gmii_rx_dv  = dv;
    gmii_rxd    = d;
    gmii_rx_err = er;
    e = cyc + 1;
  endtask

  task automatic push_out(input logic [7:0] d, input logic sop, input logic eop, input logic err, input int e);
    obs_t o;
    o.d = d; o.sop = sop; o.eop = eop; o.err = err; o.cyc = 32'(e);
    oq.push_back(o);
  endtask

  task automatic push_stat(input logic [4:0] st, input int e);
    sobs_t s;
    s.st = st; s.cyc = 32'(e);
    sq.push_back(s);
  endtask

  // Payload avoids 0x55/0xD5 so a byte seen straight after reset is never mistaken for preamble.
  task automatic build(input int n, input bit corrupt);
    logic [7:0]  b;
    logic [31:0] c;
    int          npay;
    fr.delete();
    npay = (n >= 4) ? n - 4 : n;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h55 || b == 8'hD5) b = 8'h2A;
      fr.push_back(b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    if (n >= 4) begin
      c = ~c;
      for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
      if (corrupt) fr[npay] = fr[npay] ^ 8'h01;
    end
  endtask

  task automatic send_frame(input vec_t v);
    int e;
    int n;
    build(v.nbytes, v.corrupt);
    n = v.nbytes;
    for (int i = 0; i < v.pre_n; i++) drv(1'b1, 8'h55, 1'b0, e);
    if (v.pre_bad) begin
      drv(1'b1, 8'hAA, 1'b0, e);
      push_stat(S_PRE, e);
      for (int j = 0; j < n; j++) drv(1'b1, fr[j], 1'b0, e);
      drv(1'b0, 8'h00, 1'b1, e);
      return;
    end
    drv(1'b1, 8'hD5, 1'b0, e);
    for (int j = 1; j <= n; j++) begin
      drv(1'b1, fr[j-1], (j == v.err_at), e);
      if (j >= 6) push_out(fr[j-6], (j == 6), 1'b0, 1'b0, e);
    end
    // err high on the gap cycle is carrier extension and must be ignored
    drv(1'b0, 8'h00, 1'b1, e);
    if (n >= 5) push_out(fr[n-5], (n == 5), 1'b1, (v.exp != S_GOOD), e);
    push_stat(v.exp, e);
  endtask

  task automatic check_zero(input string name);
    logic [13:0] act;
    act = {out_data, out_valid, out_sop, out_eop, out_err,
           stat_good, stat_crc_err, stat_len_err, stat_phy_err, stat_pre_err};
    n_vec++;
    if (act !== 14'h0) begin
      n_bad++;
      $display("FAIL %s: got outputs %h, want 0", name, act);
    end
  endtask

  initial begin
    vec_t vt[14];
    int   e;
    vt[0]  = '{7, 1'b0, 64,   1'b0, 0,  S_GOOD};
    vt[1]  = '{7, 1'b0, 64,   1'b1, 0,  S_CRC};
    vt[2]  = '{2, 1'b1, 70,   1'b0, 0,  S_PRE};
    vt[3]  = '{7, 1'b0, 64,   1'b0, 0,  S_GOOD};
    vt[4]  = '{7, 1'b0, 3,    1'b0, 0,  S_LEN};
    vt[5]  = '{7, 1'b0, 1600, 1'b0, 0,  S_LEN};
    vt[6]  = '{7, 1'b0, 64,   1'b0, 20, S_PHY};
    vt[7]  = '{0, 1'b0, 65,   1'b0, 0,  S_GOOD};
    vt[8]  = '{7, 1'b0, 63,   1'b0, 0,  S_LEN};
    vt[9]  = '{7, 1'b0, 5,    1'b0, 0,  S_LEN};
    vt[10] = '{7, 1'b0, 1522, 1'b0, 0,  S_GOOD};
    vt[11] = '{7, 1'b0, 1523, 1'b0, 0,  S_LEN};
    vt[12] = '{3, 1'b0, 3,    1'b0, 2,  S_PHY};
    vt[13] = '{7, 1'b0, 64,   1'b0, 64, S_PHY};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_125mhz);
    check_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_125mhz);

    for (int i = 0; i < 14; i++) send_frame(vt[i]);

    // reset asserted at byte 30 of a frame, released while dv is still high
    build(64, 1'b0);
    for (int i = 0; i < 7; i++) drv(1'b1, 8'h55, 1'b0, e);
    drv(1'b1, 8'hD5, 1'b0, e);
    for (int j = 1; j <= 29; j++) begin
      drv(1'b1, fr[j-1], 1'b0, e);
      if (j >= 6) push_out(fr[j-6], (j == 6), 1'b0, 1'b0, e);
    end
    @(negedge clk_125mhz);
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b1;
    gmii_rxd   = fr[29];
    #1 check_zero("reset_midframe");
    for (int j = 31; j <= 32; j++) begin
      drv(1'b1, fr[j-1], 1'b0, e);
      #1 check_zero("reset_hold");
    end
    @(negedge clk_125mhz);
    rst_n    = 1'b1;
    gmii_rxd = fr[32];
    e = cyc + 1;
    push_stat(S_PRE, e);
    for (int j = 34; j <= 64; j++) drv(1'b1, fr[j-1], 1'b0, e);
    drv(1'b0, 8'h00, 1'b0, e);
    send_frame(vt[0]);

    repeat (20) @(negedge clk_125mhz);
    while (oq.size() > 0) begin
      void'(oq.pop_front());
      n_vec++;
      n_bad++;
      $display("FAIL out_leftover: got no output, want a pending byte");
    end
    while (sq.size() > 0) begin
      void'(sq.pop_front());
      n_vec++;
      n_bad++;
      $display("FAIL stat_leftover: got no pulse, want a pending stat");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
